pio_ram_emu_client: RTL and testbench
=====================================

# pio_ram_emu_client

Chip-side master for the PIO RAM emulator link. It turns parallel read-burst and write requests from the design into 2-bit serial command messages on `tx_pins`, and deserializes read responses arriving on `rx_pins`. It sits directly upstream of the emulator: its `tx_pins` drive the emulator's `rx_pins`, and the emulator's `tx_pins` drive its `rx_pins`. It instantiates `sbio_transmitter` (IO_BITS=2, PAYLOAD_CYCLES=10) and `sbio_receiver` (IO_BITS=2, SKIP_CYCLES=0, PAYLOAD_CYCLES=10).

## Interface
- READ_COUNT, 1, words per read burst (1..65535), programmed into emulator after reset
- WRITE_COUNT, 1, words per write burst (1..65535), programmed into emulator after reset
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- rx_pins  in  2  serial response from emulator
- tx_pins  out  2  serial commands to emulator
- rd_addr_valid  in  1  read-burst request
- rd_addr_ready  out  1  request accepted when valid&ready
- rd_addr  in  16  burst start word address
- rd_data_valid  out  1  one-cycle pulse per received word; no backpressure
- rd_data  out  16  received word, valid with rd_data_valid
- wr_valid  in  1  write beat
- wr_ready  out  1  beat accepted when valid&ready
- wr_addr  in  16  burst start address; sampled only on the first beat of a burst
- wr_data  in  16  write word
- busy  out  1  init not done, message pending, read words outstanding, or write burst incomplete
- error  out  1  sticky: response received with no read outstanding

## Operation
- Message payload is {data[15:0], header[3:0]}, with header = {r1,w1,r0,w0}. It goes to `sbio_transmitter` unchanged.
- Per-channel codes come from the `pio_ram_emulator.vh` macros as (M&1)|((M&4)>>1): SET_COUNT, SEND_ADDR, SEND_DATA. NOP = SET_COUNT^SEND_ADDR^SEND_DATA, which is the unused fourth code. Idle channel in any message = NOP.
- Single message register `msg` (valid, payload). It is loaded only when empty. It clears on `payload_accepted`.
- FSM states:
  - INIT_RC: load r=SET_COUNT, w=NOP, data=READ_COUNT. On accept, go to INIT_WC.
  - INIT_WC: load r=NOP, w=SET_COUNT, data=WRITE_COUNT. On accept, go to IDLE.
  - IDLE: accept requests.
  - WR_DATA: load r=NOP, w=SEND_DATA, data=held write word. On accept, go to IDLE.
- In IDLE with msg empty:
  - rd_addr_ready = (rd_pending==0).
  - On handshake: load r=SEND_ADDR, w=NOP, data=rd_addr; set rd_pending=READ_COUNT.
- wr_ready = IDLE && msg empty && !(rd_addr_valid&&rd_addr_ready). Read has priority.
- Write beat with wr_left==0:
  - Load r=NOP, w=SEND_ADDR, data=wr_addr.
  - Hold wr_data; go to WR_DATA.
  - Set wr_left=WRITE_COUNT-1.
- Write beat with wr_left!=0:
  - Load r=NOP, w=SEND_DATA, data=wr_data.
  - wr_left decrements.
  - wr_addr is ignored.
- Reads and write bursts interleave freely. The channels are independent.
- Receiver `payload_received`:
  - rd_data = payload[19:4]; header bits are ignored.
  - If rd_pending!=0: rd_pending decrements. Otherwise set error and drop the word.
- Counters are 16 bits and never wrap. rd_pending is decremented only when nonzero.
- busy = state!=IDLE || msg.valid || rd_pending!=0 || wr_left!=0.

## Timing
- Reset values:
  - state=INIT_RC, msg empty, rd_pending=0, wr_left=0.
  - rd_addr_ready=0, wr_ready=0, rd_data_valid=0, rd_data=0, error=0, busy=1.
  - tx_pins=2'b11 (transmitter idle).
- Reset mid-operation aborts any message in flight and restarts INIT. The emulator must be reset together with the client. Words arriving after reset raise error.
- Message is loaded in the cycle after the handshake edge. Transmission starts per `sbio_transmitter` timing.
- Back-to-back requests: the next ready is asserted the cycle after `payload_accepted` of the previous message.
- rd_data_valid is registered: it pulses 1 cycle after the receiver's `payload_received`.
- rd_addr_ready deasserts from the handshake cycle+1 until the last word of the burst has been received.
- A write beat and an arriving read response in the same cycle are independent and both take effect.
- `payload_accepted` and a handshake in the same cycle: the handshake is not allowed, because ready requires msg empty.

## Test plan
- Reset, then idle with the emulator model (READ_COUNT=4, WRITE_COUNT=2) -> two init messages sent. busy falls once they are accepted. Emulator error_status stays 0.
- Write beats (0x0100,0xBEEF),(x,0xCAFE) -> the emulator RAM holds [0x0100]=0xBEEF and [0x0101]=0xCAFE. wr_left returns to 0.
- Read request 0x0100 after that write -> 4 rd_data_valid pulses: 0xBEEF, 0xCAFE, then RAM[0x0102], RAM[0x0103]. rd_addr_ready stays low until the 4th word.
- Read and write valid in the same cycle -> read address is sent first, then write address and data. No emulator error flags.
- Response injected on rx_pins with rd_pending=0 -> error=1 and no rd_data_valid. error stays 1 until reset.
- Reset asserted mid-message -> tx_pins=2'b11 on the next cycle. INIT_RC is sent again after reset is released.

Source files
------------

// File: rtl/pio_ram_emu_client.sv
// ---------------------------------------------------------------------------
// pio_ram_emu_client
//
// Chip-side master for the PIO RAM emulator link. Parallel read-burst and
// write requests are turned into 20-bit command messages that are shifted
// out two bits per cycle on tx_pins. Read responses arriving on rx_pins are
// deserialized and presented as one-cycle rd_data_valid pulses.
//
// Message payload: {data[15:0], r1, w1, r0, w0}. The r/w fields are the
// per-channel command codes of the read and write channels of the emulator.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   rx_pins[1:0]        serial responses from the emulator
//   tx_pins[1:0]        serial commands to the emulator (idle = 2'b11)
//   rd_addr_valid/ready read-burst request handshake, rd_addr = start word
//   rd_data_valid       one-cycle pulse per received word, rd_data = word
//   wr_valid/ready      write beat handshake, wr_addr (first beat), wr_data
//   busy                init pending, message pending, reads or writes open
//   error               sticky: response arrived with no read outstanding
//
// Also contains the sbio_transmitter / sbio_receiver serializers used by
// the client. Frame format on the pins: one start symbol 2'b00, then
// PAYLOAD_CYCLES symbols, least significant symbol first; idle is all ones.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// sbio_transmitter: accepts a payload when idle and shifts it out.
//   payload/payload_valid in, payload_accepted out (combinational pulse),
//   pins out (registered, all ones when idle or in reset).
// ---------------------------------------------------------------------------
module sbio_transmitter #(
    parameter int IO_BITS        = 2,
    parameter int PAYLOAD_CYCLES = 10
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [IO_BITS*PAYLOAD_CYCLES-1:0] payload,
    input  logic                              payload_valid,
    output logic                              payload_accepted,
    output logic [IO_BITS-1:0]                pins
);
    localparam int PW = IO_BITS * PAYLOAD_CYCLES;
    localparam int CW = $clog2(PAYLOAD_CYCLES + 1);

    logic          active;
    logic [CW-1:0] remaining;
    logic [PW-1:0] shift_reg;

    assign payload_accepted = payload_valid && !active;

    // A frame ends with one all-ones cycle before the next start symbol,
    // which lets the receiver resynchronise on every frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            active    <= 1'b0;
            remaining <= '0;
            shift_reg <= '0;
            pins      <= '1;
        end else if (!active) begin
            if (payload_valid) begin
                active    <= 1'b1;
                remaining <= CW'(PAYLOAD_CYCLES);
                shift_reg <= payload;
                pins      <= '0;
            end else begin
                pins <= '1;
            end
        end else if (remaining != '0) begin
            pins      <= shift_reg[IO_BITS-1:0];
            shift_reg <= shift_reg >> IO_BITS;
            remaining <= remaining - CW'(1);
        end else begin
            pins   <= '1;
            active <= 1'b0;
        end
    end
endmodule

// ---------------------------------------------------------------------------
// sbio_receiver: waits for the all-zero start symbol, skips SKIP_CYCLES,
// then collects PAYLOAD_CYCLES symbols (first symbol lands in the LSBs).
//   pins in, payload out, payload_received out (registered one-cycle pulse).
// ---------------------------------------------------------------------------
module sbio_receiver #(
    parameter int IO_BITS        = 2,
    parameter int SKIP_CYCLES    = 0,
    parameter int PAYLOAD_CYCLES = 10
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [IO_BITS-1:0]                pins,
    output logic [IO_BITS*PAYLOAD_CYCLES-1:0] payload,
    output logic                              payload_received
);
    localparam int PW    = IO_BITS * PAYLOAD_CYCLES;
    localparam int TOTAL = SKIP_CYCLES + PAYLOAD_CYCLES;
    localparam int CW    = $clog2(TOTAL + 1);

    logic          active;
    logic [CW-1:0] remaining;

    // Symbols are shifted in from the top so that after the last one the
    // first symbol sits in the least significant position.
    always_ff @(posedge clk) begin
        if (reset) begin
            active           <= 1'b0;
            remaining        <= '0;
            payload          <= '0;
            payload_received <= 1'b0;
        end else begin
            payload_received <= 1'b0;
            if (!active) begin
                if (pins == '0) begin
                    active    <= 1'b1;
                    remaining <= CW'(TOTAL);
                end
            end else begin
                if (remaining <= CW'(PAYLOAD_CYCLES)) begin
                    payload <= {pins, payload[PW-1:IO_BITS]};
                end
                remaining <= remaining - CW'(1);
                if (remaining == CW'(1)) begin
                    active           <= 1'b0;
                    payload_received <= 1'b1;
                end
            end
        end
    end
endmodule

// ---------------------------------------------------------------------------
// pio_ram_emu_client top
// ---------------------------------------------------------------------------
module pio_ram_emu_client #(
    parameter logic [15:0] READ_COUNT  = 16'd1,
    parameter logic [15:0] WRITE_COUNT = 16'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  rx_pins,
    output logic [1:0]  tx_pins,
    input  logic        rd_addr_valid,
    output logic        rd_addr_ready,
    input  logic [15:0] rd_addr,
    output logic        rd_data_valid,
    output logic [15:0] rd_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [15:0] wr_addr,
    input  logic [15:0] wr_data,
    output logic        busy,
    output logic        error
);
    // Emulator command macro values; the wire code of each channel is
    // (M&1)|((M&4)>>1), i.e. {M[2], M[0]}. NOP is the one unused code.
    localparam logic [2:0] MACRO_SET_COUNT = 3'd0;
    localparam logic [2:0] MACRO_SEND_ADDR = 3'd1;
    localparam logic [2:0] MACRO_SEND_DATA = 3'd4;

    localparam logic [1:0] CODE_SET_COUNT = {MACRO_SET_COUNT[2], MACRO_SET_COUNT[0]};
    localparam logic [1:0] CODE_SEND_ADDR = {MACRO_SEND_ADDR[2], MACRO_SEND_ADDR[0]};
    localparam logic [1:0] CODE_SEND_DATA = {MACRO_SEND_DATA[2], MACRO_SEND_DATA[0]};
    localparam logic [1:0] CODE_NOP       = CODE_SET_COUNT ^ CODE_SEND_ADDR ^ CODE_SEND_DATA;

    localparam logic [1:0] ST_INIT_RC = 2'd0;
    localparam logic [1:0] ST_INIT_WC = 2'd1;
    localparam logic [1:0] ST_IDLE    = 2'd2;
    localparam logic [1:0] ST_WR_DATA = 2'd3;

    function automatic logic [19:0] pack_msg(input logic [1:0] r, input logic [1:0] w,
                                             input logic [15:0] d);
        return {d, r[1], w[1], r[0], w[0]};
    endfunction

    logic [1:0]  state;
    logic        msg_valid;
    logic [19:0] msg_payload;
    logic [15:0] rd_pending;
    logic [15:0] wr_left;
    logic [15:0] wr_hold;
    logic        payload_accepted;
    logic [19:0] rx_payload;
    logic        payload_received;
    logic        rd_hs;
    logic        wr_hs;
    logic [1:0]  msg_w_code;
    logic        unused_rx_header;

    sbio_transmitter #(
        .IO_BITS        (2),
        .PAYLOAD_CYCLES (10)
    ) u_tx (
        .clk              (clk),
        .reset            (reset),
        .payload          (msg_payload),
        .payload_valid    (msg_valid),
        .payload_accepted (payload_accepted),
        .pins             (tx_pins)
    );

    sbio_receiver #(
        .IO_BITS        (2),
        .SKIP_CYCLES    (0),
        .PAYLOAD_CYCLES (10)
    ) u_rx (
        .clk              (clk),
        .reset            (reset),
        .pins             (rx_pins),
        .payload          (rx_payload),
        .payload_received (payload_received)
    );

    assign unused_rx_header = ^rx_payload[3:0];
    assign msg_w_code       = {msg_payload[2], msg_payload[0]};

    // Requests are only taken with the message register empty; a read
    // request blocks the write port in the same cycle so reads win.
    assign rd_addr_ready = (state == ST_IDLE) && !msg_valid && (rd_pending == 16'd0);
    assign rd_hs         = rd_addr_valid && rd_addr_ready;
    assign wr_ready      = (state == ST_IDLE) && !msg_valid && !rd_hs;
    assign wr_hs         = wr_valid && wr_ready;

    assign busy = (state != ST_IDLE) || msg_valid || (rd_pending != 16'd0) || (wr_left != 16'd0);

    // WR_DATA returns to IDLE only when the data message itself is taken;
    // the address message loaded in IDLE is still queued on entry and its
    // acceptance must not end the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_INIT_RC;
            msg_valid     <= 1'b0;
            msg_payload   <= '0;
            rd_pending    <= '0;
            wr_left       <= '0;
            wr_hold       <= '0;
            rd_data_valid <= 1'b0;
            rd_data       <= '0;
            error         <= 1'b0;
        end else begin
            rd_data_valid <= 1'b0;
            if (payload_accepted) begin
                msg_valid <= 1'b0;
            end

            case (state)
                ST_INIT_RC: begin
                    if (payload_accepted) begin
                        state <= ST_INIT_WC;
                    end else if (!msg_valid) begin
                        msg_valid   <= 1'b1;
                        msg_payload <= pack_msg(CODE_SET_COUNT, CODE_NOP, READ_COUNT);
                    end
                end
                ST_INIT_WC: begin
                    if (payload_accepted) begin
                        state <= ST_IDLE;
                    end else if (!msg_valid) begin
                        msg_valid   <= 1'b1;
                        msg_payload <= pack_msg(CODE_NOP, CODE_SET_COUNT, WRITE_COUNT);
                    end
                end
                ST_IDLE: begin
                    if (rd_hs) begin
                        msg_valid   <= 1'b1;
                        msg_payload <= pack_msg(CODE_SEND_ADDR, CODE_NOP, rd_addr);
                        rd_pending  <= READ_COUNT;
                    end else if (wr_hs) begin
                        msg_valid <= 1'b1;
                        if (wr_left == 16'd0) begin
                            msg_payload <= pack_msg(CODE_NOP, CODE_SEND_ADDR, wr_addr);
                            wr_hold     <= wr_data;
                            wr_left     <= WRITE_COUNT - 16'd1;
                            state       <= ST_WR_DATA;
                        end else begin
                            msg_payload <= pack_msg(CODE_NOP, CODE_SEND_DATA, wr_data);
                            wr_left     <= wr_left - 16'd1;
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (payload_accepted && (msg_w_code == CODE_SEND_DATA)) begin
                        state <= ST_IDLE;
                    end else if (!msg_valid) begin
                        msg_valid   <= 1'b1;
                        msg_payload <= pack_msg(CODE_NOP, CODE_SEND_DATA, wr_hold);
                    end
                end
                default: state <= ST_INIT_RC;
            endcase

            // A read handshake needs rd_pending==0 and a counted word needs
            // rd_pending!=0, so the two updates never collide.
            if (payload_received) begin
                if (rd_pending != 16'd0) begin
                    rd_pending    <= rd_pending - 16'd1;
                    rd_data       <= rx_payload[19:4];
                    rd_data_valid <= 1'b1;
                end else begin
                    error <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_pio_ram_emu_client.sv
// ---------------------------------------------------------------------------
// tb_pio_ram_emu_client
//
// Drives pio_ram_emu_client against a behavioural emulator model: frames on
// tx_pins are decoded into commands that update a RAM model, and read
// commands queue response frames onto rx_pins. Expected read data and RAM
// contents come from a separate shadow memory kept by the stimulus.
// ---------------------------------------------------------------------------
module tb_pio_ram_emu_client;
    localparam logic [15:0] RC = 16'd4;
    localparam logic [15:0] WC = 16'd2;

    localparam logic [1:0] C_SET  = 2'd0;
    localparam logic [1:0] C_ADDR = 2'd1;
    localparam logic [1:0] C_DATA = 2'd2;
    localparam logic [1:0] C_NOP  = 2'd3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  rx_pins = 2'b11;
    logic [1:0]  tx_pins;
    logic        rd_addr_valid = 1'b0;
    logic        rd_addr_ready;
    logic [15:0] rd_addr = '0;
    logic        rd_data_valid;
    logic [15:0] rd_data;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [15:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        busy;
    logic        error;

    int checks = 0;
    int errors = 0;

    // Emulator model state
    logic [15:0] emu_ram [logic [15:0]];
    logic [15:0] resp_q [$];
    logic [19:0] msg_log [$];
    int          emu_err = 0;
    logic [15:0] emu_rc = '0;
    logic [15:0] emu_wc = '0;
    logic [15:0] emu_waddr = '0;
    int          emu_wleft = 0;

    // Stimulus-side expectations
    logic [15:0] exp_mem [logic [15:0]];
    logic [15:0] exp_rd_q [$];
    int          rd_pulses = 0;
    bit          check_ready_en = 1'b0;

    always #5 clk = ~clk;

    pio_ram_emu_client #(
        .READ_COUNT  (RC),
        .WRITE_COUNT (WC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_pins       (rx_pins),
        .tx_pins       (tx_pins),
        .rd_addr_valid (rd_addr_valid),
        .rd_addr_ready (rd_addr_ready),
        .rd_addr       (rd_addr),
        .rd_data_valid (rd_data_valid),
        .rd_data       (rd_data),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .busy          (busy),
        .error         (error)
    );

    function automatic logic [19:0] make_msg(input logic [1:0] r, input logic [1:0] w,
                                             input logic [15:0] d);
        return {d, r[1], w[1], r[0], w[0]};
    endfunction

    function automatic logic [15:0] init_word(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] emu_get(input logic [15:0] a);
        return emu_ram.exists(a) ? emu_ram[a] : init_word(a);
    endfunction

    function automatic logic [15:0] exp_get(input logic [15:0] a);
        return exp_mem.exists(a) ? exp_mem[a] : init_word(a);
    endfunction

    function automatic logic [19:0] log_at(input int i);
        return (msg_log.size() > i) ? msg_log[i] : 20'hFFFFF;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fail_timeout(input string tag);
        checks++;
        errors++;
        $error("[TB] FAIL %s: observed timeout, expected event within cycle budget", tag);
    endtask

    // Emulator command handling: read channel first, then write channel.
    task automatic emu_handle(input logic [19:0] p);
        logic [1:0]  r;
        logic [1:0]  w;
        logic [15:0] d;
        r = {p[3], p[1]};
        w = {p[2], p[0]};
        d = p[19:4];
        msg_log.push_back(p);
        case (r)
            C_SET:  emu_rc = d;
            C_ADDR: begin
                if (emu_rc == 16'd0) emu_err++;
                for (int i = 0; i < int'(emu_rc); i++) resp_q.push_back(emu_get(d + 16'(i)));
            end
            C_DATA: emu_err++;
            default: ;
        endcase
        case (w)
            C_SET:  emu_wc = d;
            C_ADDR: begin
                if (emu_wc == 16'd0) emu_err++;
                emu_waddr = d;
                emu_wleft = int'(emu_wc);
            end
            C_DATA: begin
                if (emu_wleft == 0) begin
                    emu_err++;
                end else begin
                    emu_ram[emu_waddr] = d;
                    emu_waddr = emu_waddr + 16'd1;
                    emu_wleft--;
                end
            end
            default: ;
        endcase
    endtask

    // Emulator receive side: decode frames appearing on tx_pins.
    initial begin
        int          dcnt;
        logic [19:0] acc;
        dcnt = 0;
        acc  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                dcnt      = 0;
                emu_rc    = '0;
                emu_wc    = '0;
                emu_wleft = 0;
            end else if (dcnt == 0) begin
                if (tx_pins == 2'b00) begin
                    dcnt = 10;
                    acc  = '0;
                end
            end else begin
                acc = {tx_pins, acc[19:2]};
                dcnt--;
                if (dcnt == 0) emu_handle(acc);
            end
        end
    end

    // Emulator transmit side: serialize queued response words onto rx_pins.
    initial begin
        int          tcnt;
        logic [19:0] sh;
        tcnt = 0;
        sh   = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                rx_pins = 2'b11;
                tcnt    = 0;
                resp_q.delete();
            end else if (tcnt == 0) begin
                if (resp_q.size() != 0) begin
                    sh      = {resp_q.pop_front(), 4'h0};
                    rx_pins = 2'b00;
                    tcnt    = 10;
                end else begin
                    rx_pins = 2'b11;
                end
            end else begin
                rx_pins = sh[1:0];
                sh      = sh >> 2;
                tcnt--;
            end
        end
    end

    // Every rd_data_valid pulse must match the next expected word.
    initial begin
        logic [15:0] expw;
        forever begin
            @(negedge clk);
            if (!reset && rd_data_valid) begin
                rd_pulses++;
                if (exp_rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("[TB] FAIL unexpected_rd_data: observed pulse data=%0h, expected no pulse", rd_data);
                end else begin
                    expw = exp_rd_q.pop_front();
                    check_output("rd_data", rd_data, expw);
                    if (check_ready_en)
                        check_output("rd_addr_ready_in_burst", rd_addr_ready, exp_rd_q.size() == 0);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
        end
        if (!ok) fail_timeout(tag);
    endtask

    task automatic wait_reads_done(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (exp_rd_q.size() == 0) begin ok = 1'b1; break; end
        end
        if (!ok) fail_timeout(tag);
    endtask

    task automatic apply_write(input logic [15:0] a, input logic [15:0] d);
        bit ok;
        ok       = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        for (int i = 0; i < 300; i++) begin
            if (wr_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) fail_timeout("wr_handshake");
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic apply_read(input logic [15:0] a);
        bit ok;
        ok            = 1'b0;
        rd_addr_valid = 1'b1;
        rd_addr       = a;
        for (int i = 0; i < 300; i++) begin
            if (rd_addr_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) fail_timeout("rd_handshake");
        @(negedge clk);
        rd_addr_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] d1, d2, d3, d4, d5, ra, wa;
        int          base;
        int          p0;
        bit          ok;

        // Reset values
        reset = 1'b1;
        wait_cycles(3);
        check_output("reset_tx_pins", tx_pins, 2'b11);
        check_output("reset_busy", busy, 1'b1);
        check_output("reset_rd_addr_ready", rd_addr_ready, 1'b0);
        check_output("reset_wr_ready", wr_ready, 1'b0);
        check_output("reset_rd_data_valid", rd_data_valid, 1'b0);
        check_output("reset_rd_data", rd_data, 16'h0);
        check_output("reset_error", error, 1'b0);
        reset = 1'b0;

        // Init messages
        wait_idle("init_idle");
        wait_cycles(30);
        check_output("init_msg_count", msg_log.size(), 2);
        check_output("init_msg_rc", log_at(0), make_msg(C_SET, C_NOP, RC));
        check_output("init_msg_wc", log_at(1), make_msg(C_NOP, C_SET, WC));
        check_output("init_emu_rc", emu_rc, RC);
        check_output("init_emu_wc", emu_wc, WC);
        check_output("init_emu_err", emu_err, 0);

        // Write burst to 0x0100
        d1 = 16'($urandom);
        d2 = 16'($urandom);
        apply_write(16'h0100, d1);
        apply_write(16'($urandom), d2);
        exp_mem[16'h0100] = d1;
        exp_mem[16'h0101] = d2;
        wait_idle("write_idle");
        wait_cycles(30);
        check_output("write_ram0", emu_get(16'h0100), exp_get(16'h0100));
        check_output("write_ram1", emu_get(16'h0101), exp_get(16'h0101));
        check_output("write_busy", busy, 1'b0);
        check_output("write_emu_wleft", emu_wleft, 0);
        check_output("write_emu_err", emu_err, 0);

        // Read burst from 0x0100
        for (int i = 0; i < int'(RC); i++) exp_rd_q.push_back(exp_get(16'h0100 + 16'(i)));
        p0 = rd_pulses;
        check_ready_en = 1'b1;
        apply_read(16'h0100);
        check_output("read_ready_after_hs", rd_addr_ready, 1'b0);
        wait_reads_done("read_words");
        wait_cycles(30);
        check_ready_en = 1'b0;
        check_output("read_pulse_count", rd_pulses - p0, int'(RC));

        // Simultaneous read and write request
        wait_idle("simul_idle");
        ra = 16'h2000 | 16'($urandom_range(0, 255));
        wa = 16'h0400 | 16'($urandom_range(0, 255));
        d3 = 16'($urandom);
        d4 = 16'($urandom);
        for (int i = 0; i < int'(RC); i++) exp_rd_q.push_back(exp_get(ra + 16'(i)));
        base          = msg_log.size();
        rd_addr_valid = 1'b1;
        rd_addr       = ra;
        wr_valid      = 1'b1;
        wr_addr       = wa;
        wr_data       = d3;
        #1;
        check_output("simul_rd_ready", rd_addr_ready, 1'b1);
        check_output("simul_wr_ready", wr_ready, 1'b0);
        @(negedge clk);
        rd_addr_valid = 1'b0;
        apply_write(wa, d3);
        apply_write(16'($urandom), d4);
        exp_mem[wa]         = d3;
        exp_mem[wa + 16'd1] = d4;
        wait_reads_done("simul_reads");
        wait_idle("simul_done");
        wait_cycles(30);
        check_output("simul_msg0", log_at(base),     make_msg(C_ADDR, C_NOP, ra));
        check_output("simul_msg1", log_at(base + 1), make_msg(C_NOP, C_ADDR, wa));
        check_output("simul_msg2", log_at(base + 2), make_msg(C_NOP, C_DATA, d3));
        check_output("simul_msg3", log_at(base + 3), make_msg(C_NOP, C_DATA, d4));
        check_output("simul_ram0", emu_get(wa), exp_get(wa));
        check_output("simul_ram1", emu_get(wa + 16'd1), exp_get(wa + 16'd1));
        check_output("simul_emu_err", emu_err, 0);

        // Unsolicited response
        check_output("error_before_inject", error, 1'b0);
        p0 = rd_pulses;
        resp_q.push_back(16'($urandom));
        wait_cycles(40);
        check_output("error_after_inject", error, 1'b1);
        check_output("inject_no_pulse", rd_pulses - p0, 0);
        wait_cycles(50);
        check_output("error_sticky", error, 1'b1);

        // Reset in the middle of a message
        d5 = 16'($urandom);
        apply_write(16'h0600, d5);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (tx_pins == 2'b00) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) fail_timeout("frame_start");
        wait_cycles(3);
        reset = 1'b1;
        @(negedge clk);
        check_output("midreset_tx_pins", tx_pins, 2'b11);
        check_output("midreset_error", error, 1'b0);
        check_output("midreset_busy", busy, 1'b1);
        check_output("midreset_rd_ready", rd_addr_ready, 1'b0);
        wait_cycles(2);
        base  = msg_log.size();
        reset = 1'b0;
        ok    = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (msg_log.size() > base) begin ok = 1'b1; break; end
        end
        if (!ok) fail_timeout("reinit_msg");
        check_output("reinit_msg_rc", log_at(base), make_msg(C_SET, C_NOP, RC));
        wait_idle("reinit_idle");
        wait_cycles(30);
        check_output("reinit_emu_rc", emu_rc, RC);
        check_output("reinit_emu_wc", emu_wc, WC);
        check_output("reinit_emu_err", emu_err, 0);
        check_output("reinit_error", error, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
